// File: rtl/waveform_pkg.sv
// Shared types and band-geometry helpers for the waveform plotter.
package waveform_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    CLEAR,
    DRAW,
    NEXT
  } state_t;

  function automatic int band_h(int height, int channels);
    return height / channels;
  endfunction

  function automatic int band_lim(int height, int channels);
    return band_h(height, channels) / 2 - 1;
  endfunction

  function automatic int band_center(int height, int channels, int ch);
    return ch * band_h(height, channels) + band_h(height, channels) / 2;
  endfunction

  function automatic int clamp_off(int v, int lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/waveform_plotter_if.sv
// Sample FIFO read side and framebuffer write side of the waveform plotter.
interface waveform_plotter_if #(
  parameter int NUM_CHANNELS = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 19
);
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] sample_data;
  logic                               fifo_almost_empty;
  logic                               fifo_rd_en;
  logic [ADDR_WIDTH-1:0]              pixel_addr;
  logic                               pixel_data;
  logic                               pixel_wr_en;

  modport master (
    input  sample_data, fifo_almost_empty,
    output fifo_rd_en, pixel_addr, pixel_data, pixel_wr_en
  );

  modport slave (
    output sample_data, fifo_almost_empty,
    input  fifo_rd_en, pixel_addr, pixel_data, pixel_wr_en
  );
endinterface

// File: rtl/waveform_plotter_sample_to_row.sv
// Maps one channel's signed sample to a clamped screen row inside its band.
module sample_to_row
  import waveform_pkg::*;
#(
  parameter int SCREEN_HEIGHT = 480,
  parameter int NUM_CHANNELS  = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int SAMPLE_WIDTH  = 24,
  parameter int SCALE_SHIFT   = 16,
  parameter int CH            = 0,
  parameter int YW            = 9
) (
  input  logic [DATA_WIDTH-1:0] slot,
  output logic [YW-1:0]         y
);
  logic signed [SAMPLE_WIDTH-1:0] s;
  logic                           unused_hi;
  int                             off;

  assign s         = slot[SAMPLE_WIDTH-1:0];
  assign unused_hi = ^slot[DATA_WIDTH-1:SAMPLE_WIDTH];

  // Positive samples move up the screen, hence center minus offset.
  always_comb begin
    off = clamp_off(int'(s) >>> SCALE_SHIFT, band_lim(SCREEN_HEIGHT, NUM_CHANNELS));
    y   = YW'(band_center(SCREEN_HEIGHT, NUM_CHANNELS, CH) - off);
  end
endmodule

// File: rtl/waveform_plotter.sv
// Column-at-a-time multi-channel trace plotter into a 1-bit framebuffer.
// Define WAVE_CONNECT_EN to join consecutive samples with vertical spans.
module waveform_plotter
  import waveform_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int NUM_CHANNELS  = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int SAMPLE_WIDTH  = 24,
  parameter int SCALE_SHIFT   = 16,
  parameter int ADDR_WIDTH    = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT)
) (
  input  logic               clk,
  input  logic               resetn,
  waveform_plotter_if.master bus,
  output logic               frame_done,
  output logic               busy
);
  localparam int XW = $clog2(SCREEN_WIDTH);
  localparam int YW = $clog2(SCREEN_HEIGHT);
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [ADDR_WIDTH-1:0] STRIDE  = ADDR_WIDTH'(SCREEN_WIDTH);
  localparam logic [XW-1:0]         X_LAST  = XW'(SCREEN_WIDTH-1);
  localparam logic [YW-1:0]         Y_LAST  = YW'(SCREEN_HEIGHT-1);
  localparam logic [CW-1:0]         CH_LAST = CW'(NUM_CHANNELS-1);

  state_t state, state_n;
  logic [XW-1:0] x;
  logic [YW-1:0] row, cnt;
  logic [CW-1:0] ch, ch_nxt;
  logic [NUM_CHANNELS-1:0][YW-1:0] new_y, lo_y, lo_y_n, len, len_n;
  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] lo_addr;
  logic [ADDR_WIDTH-1:0] addr, first_addr;
  logic wr_en, data, clear_last, draw_last;

`ifdef WAVE_CONNECT_EN
  logic [NUM_CHANNELS-1:0][YW-1:0] cur_y, prev_y;
`endif

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    sample_to_row #(
      .SCREEN_HEIGHT(SCREEN_HEIGHT), .NUM_CHANNELS(NUM_CHANNELS),
      .DATA_WIDTH(DATA_WIDTH), .SAMPLE_WIDTH(SAMPLE_WIDTH),
      .SCALE_SHIFT(SCALE_SHIFT), .CH(c), .YW(YW)
    ) u_row (
      .slot(bus.sample_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .y   (new_y[c])
    );
  end

  // Span start row and length-1 per channel; column 0 never connects across the wrap.
  always_comb begin
    lo_y_n = new_y;
    len_n  = '0;
`ifdef WAVE_CONNECT_EN
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (x != '0) begin
        if (prev_y[c] < new_y[c]) begin
          lo_y_n[c] = prev_y[c];
          len_n[c]  = new_y[c] - prev_y[c];
        end else begin
          len_n[c]  = prev_y[c] - new_y[c];
        end
      end
    end
`endif
  end

  always_comb begin
    state_n    = state;
    clear_last = (row == Y_LAST);
    draw_last  = (cnt == '0) && (ch == CH_LAST);
    ch_nxt     = ch + 1'b1;
    first_addr = (row == lo_y[0]) ? addr : lo_addr[0];
    case (state)
      IDLE:    if (!bus.fifo_almost_empty) state_n = READ;
      READ:    state_n = LATCH;
      LATCH:   state_n = CLEAR;
      CLEAR:   if (clear_last) state_n = DRAW;
      DRAW:    if (draw_last) state_n = NEXT;
      NEXT:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // Write registers are loaded one cycle ahead so each write coincides with its state.
  // Span base addresses are captured as the clear sweep passes each start row.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      x       <= '0;
      row     <= '0;
      cnt     <= '0;
      ch      <= '0;
      addr    <= '0;
      data    <= 1'b0;
      wr_en   <= 1'b0;
      lo_y    <= '0;
      len     <= '0;
      lo_addr <= '0;
`ifdef WAVE_CONNECT_EN
      cur_y   <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++)
        prev_y[c] <= YW'(band_center(SCREEN_HEIGHT, NUM_CHANNELS, c));
`endif
    end else begin
      case (state)
        LATCH: begin
          lo_y  <= lo_y_n;
          len   <= len_n;
`ifdef WAVE_CONNECT_EN
          cur_y <= new_y;
`endif
          row   <= '0;
          addr  <= ADDR_WIDTH'(x);
          data  <= 1'b0;
          wr_en <= 1'b1;
        end
        CLEAR: begin
          for (int c = 0; c < NUM_CHANNELS; c++)
            if (row == lo_y[c]) lo_addr[c] <= addr;
          if (clear_last) begin
            addr <= first_addr;
            data <= 1'b1;
            ch   <= '0;
            cnt  <= len[0];
          end else begin
            row  <= row + 1'b1;
            addr <= addr + STRIDE;
          end
        end
        DRAW: begin
          if (cnt != '0) begin
            cnt  <= cnt - 1'b1;
            addr <= addr + STRIDE;
          end else if (ch == CH_LAST) begin
            wr_en <= 1'b0;
            data  <= 1'b0;
          end else begin
            ch   <= ch_nxt;
            addr <= lo_addr[ch_nxt];
            cnt  <= len[ch_nxt];
          end
        end
        NEXT: begin
`ifdef WAVE_CONNECT_EN
          prev_y <= cur_y;
`endif
          x <= (x == X_LAST) ? '0 : x + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.fifo_rd_en  = (state == READ);
  assign bus.pixel_addr  = addr;
  assign bus.pixel_data  = data;
  assign bus.pixel_wr_en = wr_en;
  assign busy            = (state != IDLE);
  assign frame_done      = (state == NEXT) && (x == X_LAST);

endmodule

// File: tb/tb_waveform_plotter.sv
// Directed bench for waveform_plotter: full-size instance plus a 4x8 instance for wrap.
module tb_waveform_plotter;
  typedef struct {
    int addr;
    bit data;
    int cyc;
  } wr_t;

`ifdef WAVE_CONNECT_EN
  localparam bit CONN = 1'b1;
`else
  localparam bit CONN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  logic frame_done, busy, frame_done2, busy2;

  waveform_plotter_if #(.NUM_CHANNELS(2), .DATA_WIDTH(32), .ADDR_WIDTH(19)) bus ();
  waveform_plotter_if #(.NUM_CHANNELS(2), .DATA_WIDTH(32), .ADDR_WIDTH(5))  bus2 ();

  waveform_plotter dut (
    .clk(clk), .resetn(resetn), .bus(bus), .frame_done(frame_done), .busy(busy)
  );

  waveform_plotter #(.SCREEN_WIDTH(4), .SCREEN_HEIGHT(8), .ADDR_WIDTH(5)) dut2 (
    .clk(clk), .resetn(resetn), .bus(bus2), .frame_done(frame_done2), .busy(busy2)
  );

  always #5 clk = ~clk;

  int  cyc = 0, busy_cyc = 0, busy_cyc2 = 0, last_rd = 0, fd = 0, fd2 = 0;
  wr_t wq[$];
  wr_t wq2[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.pixel_wr_en)
      wq.push_back('{addr: int'(bus.pixel_addr), data: bus.pixel_data, cyc: cyc});
    if (bus2.pixel_wr_en)
      wq2.push_back('{addr: int'(bus2.pixel_addr), data: bus2.pixel_data, cyc: cyc});
    if (bus.fifo_rd_en || bus2.fifo_rd_en) last_rd = cyc;
    if (busy) busy_cyc++;
    if (busy2) busy_cyc2++;
    if (frame_done) fd++;
    if (frame_done2) fd2++;
  end

  int checks = 0, fails = 0;
  int col_base, col_busy, col_rd;

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_col(input bit sel, input logic [31:0] s0, input logic [31:0] s1);
    int b0;
    bit seen;
    if (sel) begin
      bus2.sample_data = {s1, s0}; bus2.fifo_almost_empty = 1'b0;
      col_base = wq2.size(); b0 = busy_cyc2;
    end else begin
      bus.sample_data = {s1, s0}; bus.fifo_almost_empty = 1'b0;
      col_base = wq.size(); b0 = busy_cyc;
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = sel ? bus2.fifo_rd_en : bus.fifo_rd_en;
    end
    chk("rd_seen", int'(seen), 1);
    bus.fifo_almost_empty  = 1'b1;
    bus2.fifo_almost_empty = 1'b1;
    col_rd = last_rd;
    seen = 1'b1;
    for (int i = 0; i < 3000 && seen; i++) begin
      tick();
      seen = sel ? busy2 : busy;
    end
    chk("col_done", int'(seen), 0);
    col_busy = (sel ? busy_cyc2 : busy_cyc) - b0;
  endtask

  task automatic check_col(string tag, bit sel, int xx, int lo0, int hi0, int lo1, int hi1);
    wr_t q[$];
    int w, h, k, bad;
    if (sel) begin q = wq2; w = 4;   h = 8;   end
    else     begin q = wq;  w = 640; h = 480; end
    chk({tag, "_n"}, q.size() - col_base, h + (hi0 - lo0 + 1) + (hi1 - lo1 + 1));
    bad = 0;
    for (int r = 0; r < h; r++) begin
      k = col_base + r;
      if (k >= q.size()) bad++;
      else if (q[k].data || q[k].addr != r * w + xx) bad++;
    end
    chk({tag, "_clear"}, bad, 0);
    bad = 0;
    k = col_base + h;
    for (int r = lo0; r <= hi0; r++) begin
      if (k >= q.size()) bad++;
      else if (!q[k].data || q[k].addr != r * w + xx) bad++;
      k++;
    end
    for (int r = lo1; r <= hi1; r++) begin
      if (k >= q.size()) bad++;
      else if (!q[k].data || q[k].addr != r * w + xx) bad++;
      k++;
    end
    chk({tag, "_trace"}, bad, 0);
    chk({tag, "_t0"}, (col_base + h < q.size()) ? q[col_base + h].addr : -1, lo0 * w + xx);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int n;
    resetn = 1'b0;
    bus.sample_data = '0;  bus.fifo_almost_empty = 1'b0;
    bus2.sample_data = '0; bus2.fifo_almost_empty = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_rd_en", int'(bus.fifo_rd_en), 0);
      chk("rst_wr_en", int'(bus.pixel_wr_en), 0);
      chk("rst_busy", int'(busy), 0);
    end
    chk("rst_addr", int'(bus.pixel_addr), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    bus.fifo_almost_empty = 1'b1;
    bus2.fifo_almost_empty = 1'b1;
    resetn = 1'b1;
    tick();

    // column 0: zero samples sit at band centers 120 / 360
    run_col(0, 32'h0, 32'h0);
    check_col("c0", 0, 0, 120, 120, 360, 360);
    chk("c0_lat", (wq.size() > col_base) ? wq[col_base].cyc - col_rd : -1, 2);
    chk("c0_cycles", col_busy, 485);

    // column 1: ch0 off=60 -> row 60, connects up to previous row 120
    run_col(0, 32'h003C_0000, 32'h0);
    check_col("c1", 0, 1, 60, CONN ? 120 : 60, 360, 360);
    chk("c1_cycles", col_busy, CONN ? 545 : 485);

    // column 2: full-scale clamp to rows 1 and 479
    run_col(0, 32'h007F_FFFF, 32'h0080_0000);
    check_col("c2", 0, 2, 1, CONN ? 60 : 1, CONN ? 360 : 479, 479);

    // column 3: upper slot bits ignored; -1 shifts to -1 -> row 361
    run_col(0, 32'hFF00_0000, 32'h12FF_FFFF);
    check_col("c3", 0, 3, CONN ? 1 : 120, 120, 361, CONN ? 479 : 361);

    // column 4: reset during clear of row 200
    bus.sample_data = '0;
    bus.fifo_almost_empty = 1'b0;
    col_base = wq.size();
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (bus.fifo_rd_en) bus.fifo_almost_empty = 1'b1;
      seen = (wq.size() > col_base + 200);
    end
    chk("mid_row200_seen", int'(seen), 1);
    chk("mid_row200_addr", seen ? wq[col_base + 200].addr : -1, 200 * 640 + 4);
    resetn = 1'b0;
    n = wq.size();
    tick();
    chk("mid_wr_en", int'(bus.pixel_wr_en), 0);
    chk("mid_busy", int'(busy), 0);
    tick();
    tick();
    chk("mid_no_writes", wq.size() - n, 0);
    chk("mid_rd_en", int'(bus.fifo_rd_en), 0);
    resetn = 1'b1;
    tick();
    run_col(0, 32'h0, 32'h0);
    check_col("post_rst", 0, 0, 120, 120, 360, 360);
    chk("main_frame_done", fd, 0);

    // small screen: 4 columns, bands of 4 rows centered at 2 and 6
    for (int c = 0; c < 3; c++) run_col(1, 32'h0, 32'h0);
    chk("w_fd_before", fd2, 0);
    run_col(1, 32'h0, 32'h0);
    check_col("w3", 1, 3, 2, 2, 6, 6);
    chk("w_fd_once", fd2, 1);
    run_col(1, 32'h0001_0000, 32'hFFFF_0000);
    check_col("w_wrap", 1, 0, 1, 1, 7, 7);
    chk("w_fd_after", fd2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/waveform_plotter.md
# waveform_plotter

Parametrised multi-channel successor to `sample_to_pixel`. Pops one packed multi-channel sample word per screen column from the audio FIFO and scales each channel into its own horizontal band. It clears the column, then writes the trace pixels straight into the 1-bit `framebuffer`. With the connect feature, consecutive samples are joined by vertical spans, which removes the need for the external Bresenham engine. Sits between the sample FIFO and the `framebuffer` write port, in the `clk` domain.

## Interface
- `SCREEN_WIDTH`, 640, columns; x wraps at this value.
- `SCREEN_HEIGHT`, 480, rows; must be divisible by `NUM_CHANNELS`.
- `NUM_CHANNELS`, 2, traces; 1..4.
- `DATA_WIDTH`, 32, bits per channel slot in `sample_data`.
- `SAMPLE_WIDTH`, 24, signed sample occupies `[SAMPLE_WIDTH-1:0]` of each slot; upper bits ignored.
- `SCALE_SHIFT`, 16, arithmetic right shift applied to the sample to get the row offset.
- `ADDR_WIDTH`, `$clog2(SCREEN_WIDTH*SCREEN_HEIGHT)`, framebuffer address width.
- `clk  in  1  system clock, all logic rising-edge.`
- `resetn  in  1  synchronous, active-low reset.`
- `sample_data  in  NUM_CHANNELS*DATA_WIDTH  FIFO read data; channel c in slot [c*DATA_WIDTH +: DATA_WIDTH]; valid the cycle after fifo_rd_en.`
- `fifo_almost_empty  in  1  high = no word may be read.`
- `fifo_rd_en  out  1  one-cycle read strobe.`
- `pixel_addr  out  ADDR_WIDTH  y*SCREEN_WIDTH + x.`
- `pixel_data  out  1  0 = clear, 1 = trace.`
- `pixel_wr_en  out  1  write strobe, qualifies addr/data.`
- `frame_done  out  1  one-cycle pulse when the column at SCREEN_WIDTH-1 finishes.`
- `busy  out  1  high in every state except IDLE.`

## Operation
- Band geometry:
  - `BAND_H = SCREEN_HEIGHT/NUM_CHANNELS`.
  - `center_c = c*BAND_H + BAND_H/2`.
  - `LIM = BAND_H/2 - 1`.
- Row mapping:
  - `off = clamp(sext(sample) >>> SCALE_SHIFT, -LIM, +LIM)`.
  - `y_c = center_c - off`, so positive samples plot upward.
  - Each trace is confined to its own band.
- FSM: IDLE → READ → LATCH → CLEAR → DRAW → NEXT → IDLE.
  - IDLE: when `fifo_almost_empty==0`, go to READ.
  - READ: `fifo_rd_en=1` for exactly this cycle.
  - LATCH: register `sample_data`, compute `cur_y[c]` for every channel.
  - CLEAR: write `pixel_data=0` for rows 0..SCREEN_HEIGHT-1 at column x, one per cycle.
  - DRAW: for c = 0..NUM_CHANNELS-1, write `pixel_data=1` for rows `min(prev_y[c],cur_y[c])`..`max(...)` ascending, one per cycle.
  - NEXT:
    - `prev_y <= cur_y`.
    - If `x==SCREEN_WIDTH-1`: x←0 and pulse `frame_done`; else x←x+1.
- Reset values:
  - Outputs: all 0.
  - State IDLE, x=0, `prev_y[c]=center_c`.
- Column 0 never connects across the wrap: at x==0, DRAW uses `cur_y[c]` as both span ends (single pixel).
- Reset mid-column: return to IDLE immediately, with no further writes and no FIFO read. Framebuffer contents are left as-is.
- `fifo_almost_empty` is sampled only in IDLE; changes during other states are ignored.
- Address arithmetic uses `ADDR_WIDTH` bits; the row base `y*SCREEN_WIDTH` is an incremental accumulator, not a multiplier.

## Timing
- `pixel_addr`, `pixel_data`, `pixel_wr_en` are registered, one write per cycle.
- First write lands 2 cycles after `fifo_rd_en`.
- Cycles per column = 1 (READ) + 1 (LATCH) + SCREEN_HEIGHT + Σ_c span_c + 1 (NEXT), with `span_c = |prev_y[c]-cur_y[c]|+1`.
  - Best case 2 ch, 480 rows: 485.
  - Worst case: 485 + 2·(2·LIM).
- `frame_done` is asserted in the NEXT cycle of column SCREEN_WIDTH-1.
- IDLE→READ has 1-cycle latency; back-to-back columns therefore have 1 idle cycle between them.

## Configuration
- `WAVE_CONNECT_EN` defined: DRAW writes full spans as above.
- Not defined: DRAW writes exactly one pixel per channel at `cur_y[c]`. The `prev_y` registers are omitted, giving `NUM_CHANNELS` DRAW cycles per column.

## Structure
- `waveform_pkg` holds:
  - the state enum (IDLE, READ, LATCH, CLEAR, DRAW, NEXT);
  - helper functions for `BAND_H`, `LIM` and center;
  - the clamp function.
- Sub-module `sample_to_row`: one instance per channel, combinational. Inputs are the sample slot and the channel index parameter; output is `y`, clamped.
- The top level holds the FSM, the x counter, the row accumulator and the span counters.

## Test plan
- Reset state: hold `resetn=0` 3 cycles with `fifo_almost_empty=0` → `fifo_rd_en` and `pixel_wr_en` stay 0, `busy=0`.
- Zero samples, both channels, column 0: 480 clears at addr 0, 640, …, 306560, then trace writes at addr 76800 (y=120) and 230400 (y=360).
- Full-scale clamp: ch0=0x7FFFFF, ch1=0x800000 (SCALE_SHIFT=16) → ch0 writes y=1 (addr 640+x), ch1 writes y=479 (clamped −119).
- Connect: column 1 ch0 goes 0→0x3C0000 (off=60) with `WAVE_CONNECT_EN` → writes rows 60..120 at x=1 (61 writes). Without the macro → single write at row 60.
- Wrap: feed 640 columns → `frame_done` pulses once after column 639. Column 640 writes x=0 with a single-pixel trace.
- Mid-column reset: deassert `resetn` during CLEAR row 200 → no writes from the next cycle, x=0. The next column after release writes x=0.
